// File: rtl/stream_prefetch_buffer_pkg.sv
// Shared definitions for the stream prefetch buffer: width derivation,
// entry layout and fill-engine state encoding.
package stream_prefetch_buffer_pkg;

  // Widest block address any configuration can produce; entries carry this
  // width and narrower configurations zero-extend into it.
  localparam int BA_MAX_W = 32;

  function automatic int calc_block_offset_index(input int block_size_byte);
    return $clog2(block_size_byte);
  endfunction

  function automatic int calc_set_index(input int cache_size_byte,
                                        input int block_size_byte,
                                        input int way);
    return $clog2(cache_size_byte / (block_size_byte * way));
  endfunction

  function automatic int calc_ba_w(input int block_size_byte);
    return 32 - calc_block_offset_index(block_size_byte);
  endfunction

  typedef struct packed {
    logic                valid;
    logic [BA_MAX_W-1:0] ba;
  } pf_entry_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } fill_state_e;

endpackage

// File: rtl/stream_prefetch_buffer_match.sv
// Parallel compare of a block address against every buffer entry, with a
// lowest-index priority encoder. Purely combinational.
module stream_match
  import stream_prefetch_buffer_pkg::*;
#(
  parameter  int depth = 4,
  localparam int K_W   = $clog2(depth)
) (
  input  pf_entry_t [depth-1:0] entries,
  input  logic [BA_MAX_W-1:0]   ba,
  output logic                  hit,
  output logic [K_W-1:0]        k
);

  logic [depth-1:0] match_s;

  // Per-entry equality; invalid entries never match.
  always_comb begin
    match_s = '0;
    for (int i = 0; i < depth; i++) begin
      match_s[i] = entries[i].valid & (entries[i].ba == ba);
    end
  end

  // Scan from the tail down so the lowest matching index is the one kept.
  always_comb begin
    hit = 1'b0;
    k   = '0;
    for (int i = depth - 1; i >= 0; i--) begin
      hit = hit | match_s[i];
      k   = match_s[i] ? K_W'(i) : k;
    end
  end

endmodule

// File: rtl/stream_prefetch_buffer.sv
// Sequential stream-buffer prefetcher: answers cache-miss lookups against a
// small FIFO of predicted block addresses and refills it sequentially.
module stream_prefetch_buffer
  import stream_prefetch_buffer_pkg::*;
#(
  parameter  int block_size_byte = 16,
  parameter  int cache_size_byte = 32768,
  parameter  int way             = 1,
  parameter  int depth           = 4,
  parameter  int fill_latency    = 8,
  localparam int OFF_W = calc_block_offset_index(block_size_byte),
  localparam int SET_W = calc_set_index(cache_size_byte, block_size_byte, way),
  localparam int BA_W  = calc_ba_w(block_size_byte),
  localparam int TAG_W = 32 - SET_W - OFF_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lookup_req,
  input  logic [TAG_W-1:0] tag,
  input  logic [SET_W-1:0] index,
  output logic             prefetch_hit,
  output logic             lookup_done,
  output logic             fill_busy,
  output logic [31:0]      pf_hit_count,
  output logic [31:0]      pf_miss_count,
  output logic [31:0]      pf_issued_count
);

  localparam int K_W   = $clog2(depth);
  localparam int OCC_W = $clog2(depth + 1);
  localparam int CNT_W = (fill_latency > 1) ? $clog2(fill_latency) : 1;

  pf_entry_t [depth-1:0] entries_r, shifted_s, base_s, entries_next_s;
  logic [BA_W-1:0]       next_ba_r, next_ba_next_s, lookup_ba_s;
  logic [CNT_W-1:0]      fill_cnt_r, fill_cnt_next_s;
  fill_state_e           state_r, state_next_s;
  logic                  stream_valid_r;
  logic                  hit_s, miss_s, hit_lookup_s, install_s, do_install_s;
  logic [K_W-1:0]        hit_k_s;
  logic [OCC_W-1:0]      occ_s, base_occ_s, new_occ_s;
  logic                  prefetch_hit_r, lookup_done_r;
  logic [31:0]           hit_count_r, miss_count_r, issued_count_r;

  assign lookup_ba_s = {tag, index};

  stream_match #(.depth(depth)) u_match (
    .entries (entries_r),
    .ba      (BA_MAX_W'(lookup_ba_s)),
    .hit     (hit_s),
    .k       (hit_k_s)
  );

  assign miss_s       = lookup_req & ~hit_s;
  assign hit_lookup_s = lookup_req & hit_s;
  assign install_s    = (state_r == ST_FILL) && (fill_cnt_r == CNT_W'(fill_latency - 1));
  assign do_install_s = install_s & ~miss_s;

  // Occupancy of the compacted buffer (valid entries always form a prefix).
  always_comb begin
    occ_s = '0;
    for (int i = 0; i < depth; i++) begin
      occ_s = occ_s + {{(OCC_W-1){1'b0}}, entries_r[i].valid};
    end
  end

  // Drop entries 0..k on a hit and move the remainder to the head.
  always_comb begin
    shifted_s = '0;
    for (int i = 0; i < depth; i++) begin
      logic [K_W:0] src;
      src = (K_W+1)'(i) + {1'b0, hit_k_s} + (K_W+1)'(1);
      if (src < (K_W+1)'(depth)) begin
        shifted_s[i] = entries_r[src[K_W-1:0]];
      end else begin
        shifted_s[i] = '0;
      end
    end
  end

  // Pick the post-lookup buffer, then append the install at its first free slot.
  always_comb begin
    if (miss_s) begin
      base_s     = '0;
      base_occ_s = '0;
    end else if (hit_lookup_s) begin
      base_s     = shifted_s;
      base_occ_s = occ_s - OCC_W'(hit_k_s) - OCC_W'(1);
    end else begin
      base_s     = entries_r;
      base_occ_s = occ_s;
    end
    new_occ_s = base_occ_s + {{(OCC_W-1){1'b0}}, do_install_s};
    entries_next_s = '0;
    for (int i = 0; i < depth; i++) begin
      if (do_install_s && (base_occ_s == OCC_W'(i))) begin
        entries_next_s[i] = '{valid: 1'b1, ba: BA_MAX_W'(next_ba_r)};
      end else begin
        entries_next_s[i] = base_s[i];
      end
    end
  end

  // Fill FSM next state, latency counter and next prefetch address.
  always_comb begin
    state_next_s    = state_r;
    fill_cnt_next_s = fill_cnt_r;
    next_ba_next_s  = next_ba_r;
    if (miss_s) begin
      state_next_s    = ST_FILL;
      fill_cnt_next_s = '0;
      next_ba_next_s  = lookup_ba_s + BA_W'(1);
    end else begin
      case (state_r)
        ST_FILL: begin
          if (do_install_s) begin
            fill_cnt_next_s = '0;
            next_ba_next_s  = next_ba_r + BA_W'(1);
          end else begin
            fill_cnt_next_s = fill_cnt_r + CNT_W'(1);
          end
          if (new_occ_s == OCC_W'(depth)) begin
            state_next_s = ST_IDLE;
          end else begin
            state_next_s = ST_FILL;
          end
        end
        ST_IDLE: begin
          fill_cnt_next_s = '0;
          if (stream_valid_r && (new_occ_s < OCC_W'(depth))) begin
            state_next_s = ST_FILL;
          end else begin
            state_next_s = ST_IDLE;
          end
        end
        default: begin
          state_next_s    = ST_IDLE;
          fill_cnt_next_s = '0;
        end
      endcase
    end
  end

  // State, buffer contents, lookup result and statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      entries_r      <= '0;
      next_ba_r      <= '0;
      fill_cnt_r     <= '0;
      state_r        <= ST_IDLE;
      stream_valid_r <= 1'b0;
      prefetch_hit_r <= 1'b0;
      lookup_done_r  <= 1'b0;
      hit_count_r    <= 32'd0;
      miss_count_r   <= 32'd0;
      issued_count_r <= 32'd0;
    end else begin
      entries_r      <= entries_next_s;
      next_ba_r      <= next_ba_next_s;
      fill_cnt_r     <= fill_cnt_next_s;
      state_r        <= state_next_s;
      stream_valid_r <= stream_valid_r | miss_s;
      lookup_done_r  <= lookup_req;
      if (lookup_req) begin
        prefetch_hit_r <= hit_s;
      end
      if (hit_lookup_s) begin
        hit_count_r <= hit_count_r + 32'd1;
      end
      if (miss_s) begin
        miss_count_r <= miss_count_r + 32'd1;
      end
      if (do_install_s) begin
        issued_count_r <= issued_count_r + 32'd1;
      end
    end
  end

  assign prefetch_hit    = prefetch_hit_r;
  assign lookup_done     = lookup_done_r;
  assign fill_busy       = (state_r == ST_FILL);
  assign pf_hit_count    = hit_count_r;
  assign pf_miss_count   = miss_count_r;
  assign pf_issued_count = issued_count_r;

endmodule

// File: tb/tb_stream_prefetch_buffer.sv
// Directed self-checking bench for stream_prefetch_buffer (default parameters:
// 16-byte blocks, 32 KiB direct-mapped, depth 4, fill latency 8).
module tb_stream_prefetch_buffer;

  logic        clk;
  logic        rst;
  logic        lookup_req;
  logic [16:0] tag;
  logic [10:0] index;
  logic        prefetch_hit;
  logic        lookup_done;
  logic        fill_busy;
  logic [31:0] pf_hit_count;
  logic [31:0] pf_miss_count;
  logic [31:0] pf_issued_count;

  int n_assert;
  int n_fail;

  stream_prefetch_buffer dut (
    .clk             (clk),
    .rst             (rst),
    .lookup_req      (lookup_req),
    .tag             (tag),
    .index           (index),
    .prefetch_hit    (prefetch_hit),
    .lookup_done     (lookup_done),
    .fill_busy       (fill_busy),
    .pf_hit_count    (pf_hit_count),
    .pf_miss_count   (pf_miss_count),
    .pf_issued_count (pf_issued_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Drive a one-cycle lookup from a falling edge; returns at the next falling
  // edge, just after the DUT has registered the result.
  task automatic lookup(input logic [27:0] ba);
    lookup_req = 1'b1;
    tag        = ba[27:11];
    index      = ba[10:0];
    @(negedge clk);
    lookup_req = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    n_assert   = 0;
    n_fail     = 0;
    clk        = 1'b0;
    rst        = 1'b1;
    lookup_req = 1'b0;
    tag        = '0;
    index      = '0;

    wait_cycles(3);
    check("rst_hit",    {31'd0, prefetch_hit}, 32'd0);
    check("rst_done",   {31'd0, lookup_done},  32'd0);
    check("rst_busy",   {31'd0, fill_busy},    32'd0);
    check("rst_hitcnt", pf_hit_count,          32'd0);
    check("rst_miscnt", pf_miss_count,         32'd0);
    check("rst_isscnt", pf_issued_count,       32'd0);
    rst = 1'b0;
    wait_cycles(1);
    check("idle_no_stream", {31'd0, fill_busy}, 32'd0);

    // First miss allocates a stream at 0x101.
    lookup(28'h100);
    check("miss100_hit",  {31'd0, prefetch_hit}, 32'd0);
    check("miss100_done", {31'd0, lookup_done},  32'd1);
    check("miss100_cnt",  pf_miss_count,         32'd1);
    check("miss100_busy", {31'd0, fill_busy},    32'd1);
    check("miss100_iss",  pf_issued_count,       32'd0);
    wait_cycles(7);
    check("fill_pre1",    pf_issued_count,       32'd0);
    check("done_pulse",   {31'd0, lookup_done},  32'd0);
    wait_cycles(1);
    check("fill_first",   pf_issued_count,       32'd1);
    wait_cycles(24);
    check("fill_full",    pf_issued_count,       32'd4);
    check("full_idle",    {31'd0, fill_busy},    32'd0);

    // Hit in the middle: {101..104} -> {103,104}, refill restarts.
    lookup(28'h102);
    check("hit102_hit",   {31'd0, prefetch_hit}, 32'd1);
    check("hit102_cnt",   pf_hit_count,          32'd1);
    check("hit102_mcnt",  pf_miss_count,         32'd1);
    check("hit102_busy",  {31'd0, fill_busy},    32'd1);
    wait_cycles(7);
    check("refill_pre",   pf_issued_count,       32'd4);

    // Lookup 0x103 on the same edge that 0x105 installs.
    lookup(28'h103);
    check("hit103_hit",   {31'd0, prefetch_hit}, 32'd1);
    check("hit103_cnt",   pf_hit_count,          32'd2);
    check("hit103_iss",   pf_issued_count,       32'd5);
    wait_cycles(1);

    // Miss mid-fill aborts the pending 0x106 install.
    lookup(28'h2FF);
    check("miss2ff_hit",  {31'd0, prefetch_hit}, 32'd0);
    check("miss2ff_cnt",  pf_miss_count,         32'd2);
    check("miss2ff_busy", {31'd0, fill_busy},    32'd1);
    check("miss2ff_iss",  pf_issued_count,       32'd5);
    wait_cycles(7);
    check("abort_no_iss", pf_issued_count,       32'd5);
    wait_cycles(1);
    check("new_first",    pf_issued_count,       32'd6);
    lookup(28'h300);
    check("hit300_hit",   {31'd0, prefetch_hit}, 32'd1);
    check("hit300_cnt",   pf_hit_count,          32'd3);
    lookup(28'h104);
    check("stale104_hit", {31'd0, prefetch_hit}, 32'd0);
    check("stale104_cnt", pf_miss_count,         32'd3);

    // Back-to-back lookup with the all-ones block address: next_ba wraps to 0.
    lookup(28'hFFFFFFF);
    check("missff_hit",   {31'd0, prefetch_hit}, 32'd0);
    check("missff_cnt",   pf_miss_count,         32'd4);
    check("missff_done",  {31'd0, lookup_done},  32'd1);
    wait_cycles(7);
    check("wrap_pre",     pf_issued_count,       32'd6);
    wait_cycles(1);
    check("wrap_inst",    pf_issued_count,       32'd7);
    lookup(28'h0);
    check("hit0_hit",     {31'd0, prefetch_hit}, 32'd1);
    check("hit0_cnt",     pf_hit_count,          32'd4);

    // Reset during FILL, together with a lookup that reset must override.
    rst        = 1'b1;
    lookup_req = 1'b1;
    tag        = 17'd0;
    index      = 11'd1;
    @(negedge clk);
    lookup_req = 1'b0;
    check("mrst_hit",     {31'd0, prefetch_hit}, 32'd0);
    check("mrst_done",    {31'd0, lookup_done},  32'd0);
    check("mrst_busy",    {31'd0, fill_busy},    32'd0);
    check("mrst_hitcnt",  pf_hit_count,          32'd0);
    check("mrst_miscnt",  pf_miss_count,         32'd0);
    check("mrst_isscnt",  pf_issued_count,       32'd0);
    wait_cycles(6);
    check("mrst_no_inst", pf_issued_count,       32'd0);
    rst = 1'b0;
    lookup(28'h1);
    check("post_rst_hit", {31'd0, prefetch_hit}, 32'd0);
    check("post_rst_mc",  pf_miss_count,         32'd1);
    check("post_rst_bsy", {31'd0, fill_busy},    32'd1);
    wait_cycles(8);
    check("post_rst_iss", pf_issued_count,       32'd1);
    lookup(28'h2);
    check("hit2_hit",     {31'd0, prefetch_hit}, 32'd1);
    check("hit2_cnt",     pf_hit_count,          32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
